// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and sequencer for a single-ported data memory,
// with an atomic lock per requester (bounded by a timeout) and an out-of-range check.
module dmem_arbiter #(
    parameter int unsigned MEM_BYTES = 128,
    parameter int unsigned LOCK_MAX  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  req_valid,
    input  logic [31:0] req_addr0,
    input  logic [31:0] req_addr1,
    input  logic [31:0] req_wdata0,
    input  logic [31:0] req_wdata1,
    input  logic [3:0]  req_we0,
    input  logic [3:0]  req_we1,
    input  logic [1:0]  req_lock,
    output logic [1:0]  req_ready,
    output logic [1:0]  rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        lock_timeout,
    output logic [31:0] mem_daddr,
    output logic [31:0] mem_dwdata,
    output logic [3:0]  mem_we,
    input  logic [31:0] mem_drdata,
    output logic [1:0]  dbg_state
);

    localparam int unsigned CW = $clog2(LOCK_MAX + 1);

    // Handshake: a request transfers in the cycle where req_valid[i] & req_ready[i];
    // req_ready is one-hot or zero and is a function of req_valid, FSM state and rr_q.
    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } state_e;

    state_e        state_q;
    logic          rr_q;
    logic [CW-1:0] cnt_q;
    logic [1:0]    rsp_valid_q;
    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          lock_timeout_q;

    logic [1:0]    ready;
    logic          accept;
    logic          sel;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_we;
    logic          acc_lock;
    logic [31:0]   word_addr;
    logic          oor;

    always_comb begin
        ready = 2'b00;
        case (state_q)
            UNLOCKED: begin
                if (req_valid == 2'b11) begin
                    ready = rr_q ? 2'b01 : 2'b10;
                end else begin
                    ready = req_valid;
                end
            end
            LOCKED0: ready = {1'b0, req_valid[0]};
            LOCKED1: ready = {req_valid[1], 1'b0};
            default: ready = 2'b00;
        endcase
    end

    assign accept    = |ready;
    assign sel       = ready[1];
    assign acc_addr  = sel ? req_addr1  : req_addr0;
    assign acc_wdata = sel ? req_wdata1 : req_wdata0;
    assign acc_we    = sel ? req_we1    : req_we0;
    assign acc_lock  = sel ? req_lock[1] : req_lock[0];
    assign word_addr = acc_addr & 32'hFFFF_FFFC;
    // 33-bit compare so a word near the top of the address space cannot wrap.
    assign oor       = ({1'b0, word_addr} + 33'd3) >= 33'(MEM_BYTES);

    assign req_ready  = ready;
    assign mem_daddr  = accept ? word_addr : 32'h0;
    assign mem_dwdata = accept ? acc_wdata : 32'h0;
    assign mem_we     = (accept && !oor && rst_n) ? acc_we : 4'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= UNLOCKED;
            rr_q           <= 1'b1;
            cnt_q          <= '0;
            rsp_valid_q    <= 2'b00;
            rsp_rdata_q    <= 32'h0;
            rsp_err_q      <= 1'b0;
            lock_timeout_q <= 1'b0;
        end else begin
            rsp_valid_q    <= ready;
            rsp_err_q      <= accept & oor;
            lock_timeout_q <= 1'b0;
            if (accept) begin
                rsp_rdata_q <= oor ? 32'h0 : mem_drdata;
                rr_q        <= sel;
            end
            case (state_q)
                UNLOCKED: begin
                    if (accept && acc_lock) begin
                        state_q <= sel ? LOCKED1 : LOCKED0;
                        cnt_q   <= '0;
                    end
                end
                LOCKED0, LOCKED1: begin
                    // Only the owner can be accepted here, so accept implies sel == owner.
                    if (accept) begin
                        cnt_q <= '0;
                        if (!acc_lock) begin
                            state_q <= UNLOCKED;
                        end
                    end else if (cnt_q == CW'(LOCK_MAX - 1)) begin
                        // This increment would make the count LOCK_MAX: release instead.
                        state_q        <= UNLOCKED;
                        cnt_q          <= '0;
                        lock_timeout_q <= 1'b1;
                        rr_q           <= (state_q == LOCKED1);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= UNLOCKED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign lock_timeout = lock_timeout_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-lane memory model behind it.
module tb_dmem_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [31:0] req_addr0, req_addr1;
  logic [31:0] req_wdata0, req_wdata1;
  logic [3:0]  req_we0, req_we1;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        lock_timeout;
  logic [31:0] mem_daddr, mem_dwdata;
  logic [3:0]  mem_we;
  logic [31:0] mem_drdata;
  logic [1:0]  dbg_state;

  logic [31:0] mem_model [0:31];
  logic        mem_init_done;
  int          n_checks;
  int          n_fail;

  dmem_arbiter #(.MEM_BYTES(128), .LOCK_MAX(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .req_we0(req_we0), .req_we1(req_we1), .req_lock(req_lock),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .lock_timeout(lock_timeout),
    .mem_daddr(mem_daddr), .mem_dwdata(mem_dwdata), .mem_we(mem_we),
    .mem_drdata(mem_drdata), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // memory model: combinational read, byte-lane write on posedge
  assign mem_drdata = mem_model[mem_daddr[6:2]];
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 32; i++) mem_model[i] <= 32'h0;
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (mem_we[b]) mem_model[mem_daddr[6:2]][b*8 +: 8] <= mem_dwdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, input logic lk);
    req_valid[0] = v; req_addr0 = a; req_wdata0 = d; req_we0 = w; req_lock[0] = lk;
  endtask

  task automatic set_p1(input logic v, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, input logic lk);
    req_valid[1] = v; req_addr1 = a; req_wdata1 = d; req_we1 = w; req_lock[1] = lk;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mem_init_done = 1'b0;
    rst_n = 1'b0;
    req_valid = 2'b00; req_lock = 2'b00;
    req_addr0 = 0; req_addr1 = 0; req_wdata0 = 0; req_wdata1 = 0; req_we0 = 0; req_we1 = 0;
    step();
    mem_init_done = 1'b1;

    // reset state, with a write request held during reset
    set_p0(1'b1, 32'h4, 32'h1111_1111, 4'hF, 1'b0);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_rdata", rsp_rdata, 32'h0);
    chk("rst_rsp_err", 32'(rsp_err), 32'h0);
    chk("rst_lock_timeout", 32'(lock_timeout), 32'h0);
    chk("rst_state", 32'(dbg_state), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    step();
    chk("rst_no_write", mem_model[1], 32'h0);
    rst_n = 1'b1;

    // write then read-back of the same word on port 0
    set_p0(1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 1'b0);
    #1;
    chk("wr_ready", 32'(req_ready), 32'h1);
    chk("wr_mem_we", 32'(mem_we), 32'hF);
    chk("wr_mem_daddr", mem_daddr, 32'h4);
    step();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    set_p0(1'b1, 32'h6, 32'h0, 4'h0, 1'b0);
    #1;
    chk("rd_mem_daddr", mem_daddr, 32'h4);
    step();
    chk("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("rd_rsp_err", 32'(rsp_err), 32'h0);

    // partial write of byte 1 from port 1; response carries the pre-write word
    set_p0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_p1(1'b1, 32'h4, 32'h0000_AB00, 4'b0010, 1'b0);
    #1;
    chk("pw_ready", 32'(req_ready), 32'h2);
    step();
    chk("pw_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("pw_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("pw_mem", mem_model[1], 32'hDEAD_ABEF);

    // round robin: both valid for four cycles -> 0,1,0,1
    set_p0(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    set_p1(1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_ready", 32'(req_ready), (k % 2 == 0) ? 32'h1 : 32'h2);
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), (k % 2 == 0) ? 32'h1 : 32'h2);
      chk("rr_rsp_rdata", rsp_rdata, (k % 2 == 0) ? 32'hDEAD_ABEF : 32'h0);
    end

    // point rr at port 0 so port 1 wins the next tie
    set_p1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    #1;
    chk("pre_lock_ready", 32'(req_ready), 32'h1);
    step();

    // port 1 lock sequence of three accesses while port 0 stays valid
    set_p1(1'b1, 32'h4, 32'h0, 4'h0, 1'b1);
    set_p0(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    #1;
    chk("lk1_c0_ready", 32'(req_ready), 32'h2);
    step();
    chk("lk1_c0_state", 32'(dbg_state), 32'h2);
    chk("lk1_c0_rdata", rsp_rdata, 32'hDEAD_ABEF);
    set_p1(1'b1, 32'h8, 32'h1234_5678, 4'hF, 1'b1);
    #1;
    chk("lk1_c1_ready", 32'(req_ready), 32'h2);
    step();
    chk("lk1_c1_rdata", rsp_rdata, 32'h0);
    set_p1(1'b1, 32'h8, 32'h0, 4'h0, 1'b0);
    #1;
    chk("lk1_c2_ready", 32'(req_ready), 32'h2);
    step();
    chk("lk1_c2_rdata", rsp_rdata, 32'h1234_5678);
    chk("lk1_c2_state", 32'(dbg_state), 32'h0);
    #1;
    chk("lk1_c3_ready", 32'(req_ready), 32'h1);
    step();
    chk("lk1_c3_rsp_valid", 32'(rsp_valid), 32'h1);

    // port 0 locks then idles until the timeout
    set_p1(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_p0(1'b1, 32'h4, 32'h0, 4'h0, 1'b1);
    #1;
    chk("lk0_ready", 32'(req_ready), 32'h1);
    step();
    chk("lk0_state", 32'(dbg_state), 32'h1);
    set_p0(1'b0, 32'h4, 32'h0, 4'h0, 1'b0);
    set_p1(1'b1, 32'h80, 32'hFFFF_FFFF, 4'hF, 1'b0);
    for (int k = 0; k < 15; k++) begin
      #1;
      chk("lk0_hold_ready", 32'(req_ready), 32'h0);
      chk("lk0_hold_we", 32'(mem_we), 32'h0);
      chk("lk0_hold_timeout", 32'(lock_timeout), 32'h0);
      step();
    end
    chk("lk0_pre_timeout", 32'(lock_timeout), 32'h0);
    chk("lk0_pre_state", 32'(dbg_state), 32'h1);
    step();
    set_p0(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    #1;
    chk("lk0_timeout", 32'(lock_timeout), 32'h1);
    chk("lk0_to_state", 32'(dbg_state), 32'h0);
    chk("lk0_to_ready", 32'(req_ready), 32'h2);

    // that port 1 access is out of range
    chk("oor_mem_we", 32'(mem_we), 32'h0);
    chk("oor_mem_daddr", mem_daddr, 32'h80);
    step();
    chk("oor_timeout_pulse", 32'(lock_timeout), 32'h0);
    chk("oor_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("oor_rsp_err", 32'(rsp_err), 32'h1);
    chk("oor_rsp_rdata", rsp_rdata, 32'h0);
    chk("oor_mem_unchanged", mem_model[0], 32'h0);

    // reset while LOCKED1 with a response pending
    set_p0(1'b0, 32'h0, 32'h0, 4'h0, 1'b0);
    set_p1(1'b1, 32'hC, 32'h0000_0055, 4'hF, 1'b1);
    #1;
    chk("rl_ready", 32'(req_ready), 32'h2);
    step();
    chk("rl_rsp_valid", 32'(rsp_valid), 32'h2);
    chk("rl_state", 32'(dbg_state), 32'h2);
    set_p0(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    set_p1(1'b1, 32'hC, 32'hAAAA_AAAA, 4'hF, 1'b1);
    #1;
    chk("rl_locked_we", 32'(mem_we), 32'hF);
    rst_n = 1'b0;
    #1;
    chk("rl_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rl_rst_timeout", 32'(lock_timeout), 32'h0);
    chk("rl_rst_mem_we", 32'(mem_we), 32'h0);
    chk("rl_rst_state", 32'(dbg_state), 32'h0);
    step();
    chk("rl_rst_mem_kept", mem_model[3], 32'h0000_0055);
    set_p0(1'b1, 32'hC, 32'h0, 4'h0, 1'b0);
    set_p1(1'b1, 32'h4, 32'h0, 4'h0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("rl_tie_ready", 32'(req_ready), 32'h1);
    step();
    chk("rl_tie_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rl_tie_rdata", rsp_rdata, 32'h0000_0055);

    req_valid = 2'b00;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer in front of the single-ported, byte-addressed data memory (combinational read, 4-lane byte-write on the clock edge). Shares the memory between requester 0 (core load/store unit) and requester 1 (debug/DMA port) with round-robin arbitration, an optional lock for atomic read-modify-write sequences with a lock timeout, and an out-of-range check. Every accepted access returns a registered one-cycle response to its requester.

## Interface
- MEM_BYTES, default 128: memory size in bytes; word addresses at or above it are out of range.
- LOCK_MAX, default 16: maximum cycles a lock may be held before it is force-released.

- clk  in  1  single clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid[1:0]  in  2  request valid, one bit per requester i.
- req_addr0 / req_addr1  in  32  byte address; word-aligned internally (addr & ~3).
- req_wdata0 / req_wdata1  in  32  write data.
- req_we0 / req_we1  in  4  byte-lane write enables; 0 means read.
- req_lock[1:0]  in  2  hold the grant after this access.
- req_ready[1:0]  out  2  combinational accept; access transfers when valid & ready.
- rsp_valid[1:0]  out  2  one-cycle response pulse, cycle after acceptance.
- rsp_rdata  out  32  registered word read at the accepted address (shared by both ports).
- rsp_err  out  1  accepted access was out of range; qualified by rsp_valid.
- lock_timeout  out  1  one-cycle pulse when a lock is force-released.
- mem_daddr  out  32  to memory address.
- mem_dwdata  out  32  to memory write data.
- mem_we  out  4  to memory byte enables.
- mem_drdata  in  32  from memory read data (combinational).

## Operation
- At most one requester accepted per cycle; req_ready is one-hot or zero.
- Lock FSM states: UNLOCKED, LOCKED0, LOCKED1.
  - UNLOCKED: both valid -> winner is the port not granted last (rr pointer); single valid -> that port. Reset pointer = 1, so port 0 wins the first tie.
  - An accepted access with req_lock[i]=1 -> LOCKEDi. In LOCKEDi only port i can be ready; the other port's ready = 0.
  - LOCKEDi: an accepted access from i with req_lock[i]=0 -> UNLOCKED (that access still executes).
  - Lock counter clears on entering LOCKEDi, increments every cycle in LOCKEDi, and clears on every accepted access by i. When it reaches LOCK_MAX -> UNLOCKED, lock_timeout pulses, rr pointer = i (other port wins next tie). An access accepted in the same cycle as the timeout takes priority: no timeout, counter clears.
- rr pointer updates to the accepted port on every accept.
- Accepted access: mem_daddr = addr & 32'hFFFF_FFFC, mem_dwdata = wdata, mem_we = we. Memory commits on that edge. rsp_rdata captures mem_drdata (the pre-write word) on the same edge.
- Out of range (word address + 3 >= MEM_BYTES): accepted, mem_we forced to 0, rsp_err = 1, rsp_rdata = 0.
- No accept: mem_daddr = 0, mem_dwdata = 0, mem_we = 0 (no spurious writes).
- rsp_valid[i] = 1 exactly one cycle after port i's accept; the other bit is 0.

## Timing
- Reset: rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, lock_timeout = 0, FSM = UNLOCKED, rr pointer = 1, lock counter = 0. Combinational outputs follow inputs from that state.
- Reset asserted mid-lock or mid-response drops the lock and any pending rsp_valid immediately. No memory write can occur while rst_n = 0, because mem_we is forced to 0.
- Accept-to-response latency: 1 cycle. Throughput: 1 access per cycle, back-to-back on the same port allowed.
- A write followed by a read of the same word on the next cycle returns the new data.
- req_ready depends on req_valid, FSM and rr pointer only, never on rsp state.

## Test plan
- Reset, then port 0 writes addr 0x04, we=4'hF, data 0xDEADBEEF. Next cycle port 0 reads 0x06. Required: rsp_rdata = 0xDEADBEEF one cycle later, rsp_err = 0.
- Both ports valid for 4 cycles. Required: grants 0,1,0,1 and rsp_valid alternates; partial write we=4'b0010 data 0x0000AB00 changes only byte 1.
- Port 1 locks at cycle 0 and issues 3 accesses (last with lock=0) while port 0 stays valid. Required: port 0 ready = 0 until the cycle after the unlocking access, then port 0 is granted.
- Port 0 locks then idles, LOCK_MAX = 16. Required: lock_timeout pulses 16 cycles after entry, port 1 is granted next cycle, and no write occurs meanwhile.
- Port 1 writes addr 0x80 (MEM_BYTES = 128). Required: mem_we = 0, rsp_err = 1, rsp_rdata = 0, memory unchanged.
- Assert rst_n low while LOCKED1 with a response pending. Required: rsp_valid, lock_timeout and mem_we = 0 at once, and the first tie after release goes to port 0.
